multiplier_unit: RTL and testbench
==================================

// Module: multiplier_unit
// PURPOSE
//  RV32M multiply execution unit (MUL/MULH/MULHSU/MULHU) in the execute stage, beside the ALU/divider.
//  Iterative radix-2 shift-add engine on operand magnitudes with a final sign fix.
//  Optional approximate mode truncates low operand bits under run-time accuracy control.
//  mul_unit_busy stalls the pipeline until the result is ready.
// PARAMETERS
//  APPROXIMATE  0  1 = honour accuracy_level/ACCURACY truncation; 0 = always exact
//  ACCURACY     0  truncation bit count used when APPROXIMATE=1 and accuracy_level==0 (0..31)
// PORTS
//  One clock; reset is synchronous and active-low.
//  clk             in   1   rising-edge clock
//  reset           in   1   synchronous, active-low reset
//  opcode          in   7   instruction opcode
//  funct7          in   7   instruction funct7
//  funct3          in   3   instruction funct3 (selects multiply variant)
//  accuracy_level  in   8   run-time approximation level (bits [4:0] used)
//  bus_rs1         in   32  operand rs1
//  bus_rs2         in   32  operand rs2
//  mul_unit_busy   out  1   high while a valid multiply is present and its result is not ready
//  mul_output      out  32  result register
// BEHAVIOUR
//  - Valid op: opcode==7'b0110011 && funct7==7'b0000001 && funct3[2]==0.
//    funct3 000 MUL: prod[31:0]; 001 MULH: s*s prod[63:32]; 010 MULHSU: s(rs1)*u(rs2) [63:32];
//    011 MULHU: u*u [63:32]. funct3[2]==1 (divide) and all other opcodes are ignored.
//  - Sign handling: signed operands are converted to 32-bit magnitudes (0x80000000 -> 2^31).
//    Result sign = XOR of the operand signs that are treated as signed. Negate the 64-bit product if negative.
//  - Approximation: if APPROXIMATE=1, N = accuracy_level[4:0], or ACCURACY if accuracy_level==0.
//    Clear the low N bits of both magnitudes before multiplying. If APPROXIMATE=0, N=0 and accuracy_level is ignored.
//  - FSM states IDLE, CALC, DONE:
//    IDLE: on a valid op at a clk edge, latch magnitudes, signs, funct3 and inputs; clear the accumulator and counter; go to CALC.
//    CALC: each edge adds (multiplicand << k) when multiplier bit k is set; k = 0..31 (32 edges).
//      On the edge with k==31, write the sign-corrected selected half to mul_output and go to DONE.
//    DONE: mul_output holds. Stay in DONE while opcode/funct7/funct3/rs1/rs2/accuracy_level equal the latched copy.
//      Any difference returns to IDLE; a new valid op then restarts, so back-to-back identical instructions need an intervening change.
//  - Latency: result is registered 33 rising edges after a valid op is first sampled (1 latch + 32 iterate).
//  - mul_unit_busy is combinational: valid_op && !(state==DONE && inputs match latched). It is 0 for invalid ops and 0 while reset is low.
//  - Operand or op change during CALC: the computation continues on the latched values. On reaching DONE, the mismatch sends the FSM to IDLE and it restarts on the new inputs.
//  - Reset (reset==0 at an edge): state=IDLE, counter=0, accumulator=0, mul_output=32'd0, latched copies cleared. Abort any operation in progress.
//  - Invalid op while IDLE: no state change; mul_output keeps its last value.
// TESTING
//  1. APPROXIMATE=0, MUL, rs1=10, rs2=20, accuracy_level=0/1/2 -> mul_output=200 every time.
//     busy=1 for exactly 33 edges, then 0.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001;
//     MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  3. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULH -7*3 -> 0xFFFFFFFF; MUL -7*3 -> 0xFFFFFFEB.
//  4. APPROXIMATE=1, MUL 10*20, accuracy_level=2 -> 160.
//     accuracy_level=0 with ACCURACY=0 -> 200; accuracy_level=0 with ACCURACY=3 -> 8*16=128.
//  5. Assert reset low at CALC edge 10 -> mul_output=0, busy=0 while low.
//     After release with the same op held -> full 33-edge restart with the correct result.
//  6. opcode=0110011, funct7=0000001, funct3=100 (DIV) or funct7=0 (ADD) -> busy=0, mul_output unchanged.
//     An input change in DONE -> busy=1 the same cycle.

Source files
------------

// File: rtl/multiplier_unit_if.sv
// multiplier_unit_if: instruction/operand bundle and result/stall signals of the multiply unit
interface multiplier_unit_if;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [7:0] accuracy_level;
  logic [31:0] bus_rs1;
  logic [31:0] bus_rs2;
  logic mul_unit_busy;
  logic [31:0] mul_output;
  modport master(
    output opcode, funct7, funct3, accuracy_level, bus_rs1, bus_rs2,
    input mul_unit_busy, mul_output
  );
  modport slave(
    input opcode, funct7, funct3, accuracy_level, bus_rs1, bus_rs2,
    output mul_unit_busy, mul_output
  );
endinterface

// File: rtl/multiplier_unit.sv
// multiplier_unit: RV32M iterative shift-add multiplier with optional operand truncation
module multiplier_unit #(
  parameter int APPROXIMATE = 0,
  parameter int ACCURACY = 0
) (
  input logic clk,
  input logic reset,
  multiplier_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [63:0] acc;
  logic [31:0] mcand, mplier, res;
  logic neg;
  logic [6:0] l_opcode, l_funct7;
  logic [2:0] l_funct3;
  logic [7:0] l_al;
  logic [31:0] l_rs1, l_rs2;
  logic valid_op, same, s1, s2;
  logic [4:0] n;
  logic [31:0] mask, m1, m2;
  logic [63:0] acc_next, prod;
  assign valid_op = bus.opcode == 7'b0110011 && bus.funct7 == 7'b0000001 && !bus.funct3[2];
  assign same = bus.opcode == l_opcode && bus.funct7 == l_funct7 && bus.funct3 == l_funct3 &&
                bus.accuracy_level == l_al && bus.bus_rs1 == l_rs1 && bus.bus_rs2 == l_rs2;
  assign s1 = bus.funct3[1:0] != 2'b11 && bus.bus_rs1[31];
  assign s2 = !bus.funct3[1] && bus.bus_rs2[31];
  assign n = APPROXIMATE != 0 ? (bus.accuracy_level == 8'd0 ? 5'(ACCURACY) : bus.accuracy_level[4:0]) : 5'd0;
  assign mask = 32'hFFFF_FFFF << n;
  assign m1 = (s1 ? -bus.bus_rs1 : bus.bus_rs1) & mask;
  assign m2 = (s2 ? -bus.bus_rs2 : bus.bus_rs2) & mask;
  assign acc_next = acc + (mplier[cnt] ? {32'd0, mcand} << cnt : 64'd0);
  assign prod = neg ? -acc_next : acc_next;
  assign bus.mul_unit_busy = reset && valid_op && !(state == DONE && same);
  assign bus.mul_output = res;
  // latch a valid op, accumulate one multiplier bit per edge, then hold until the inputs change
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 5'd0;
      acc <= 64'd0;
      mcand <= 32'd0;
      mplier <= 32'd0;
      neg <= 1'b0;
      res <= 32'd0;
      l_opcode <= 7'd0;
      l_funct7 <= 7'd0;
      l_funct3 <= 3'd0;
      l_al <= 8'd0;
      l_rs1 <= 32'd0;
      l_rs2 <= 32'd0;
    end else begin
      case (state)
        IDLE: if (valid_op) begin
          l_opcode <= bus.opcode;
          l_funct7 <= bus.funct7;
          l_funct3 <= bus.funct3;
          l_al <= bus.accuracy_level;
          l_rs1 <= bus.bus_rs1;
          l_rs2 <= bus.bus_rs2;
          mcand <= m1;
          mplier <= m2;
          neg <= s1 ^ s2;
          acc <= 64'd0;
          cnt <= 5'd0;
          state <= CALC;
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            res <= l_funct3[1:0] == 2'b00 ? prod[31:0] : prod[63:32];
            state <= DONE;
          end
        end
        DONE: if (!same) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_unit.sv
// tb_multiplier_unit: directed checks of exact and approximate multiply variants, latency, reset and hold
module tb_multiplier_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [7:0] al;
  logic [31:0] rs1, rs2;
  logic [2:0] busy;
  logic [31:0] out [3];
  int checks = 0;
  int failures = 0;
  int n;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    multiplier_unit_if bus();
    assign bus.opcode = opcode;
    assign bus.funct7 = funct7;
    assign bus.funct3 = funct3;
    assign bus.accuracy_level = al;
    assign bus.bus_rs1 = rs1;
    assign bus.bus_rs2 = rs2;
    assign busy[g] = bus.mul_unit_busy;
    assign out[g] = bus.mul_output;
    multiplier_unit #(.APPROXIMATE(g == 0 ? 0 : 1), .ACCURACY(g == 2 ? 3 : 0)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [7:0] l);
    opcode = 7'b0110011;
    funct7 = 7'b0000001;
    funct3 = f3;
    rs1 = a;
    rs2 = b;
    al = l;
    #1;
  endtask
  task automatic wait_done();
    n = 0;
    while (busy[0] && n < 100) begin
      edge1();
      n++;
    end
  endtask
  task automatic go(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [7:0] l);
    opcode = 7'd0;
    edge1();
    set_op(f3, a, b, l);
    wait_done();
    chk("latency", 32'(n), 32'd33);
  endtask
  initial begin
    set_op(3'b000, 32'd10, 32'd20, 8'd0);
    edge1();
    edge1();
    chk("reset_busy", {31'd0, busy[0]}, 32'd0);
    chk("reset_out", out[0], 32'd0);
    reset = 1'b1;
    #1;
    chk("busy_start", {31'd0, busy[0]}, 32'd1);
    wait_done();
    chk("latency_first", 32'(n), 32'd33);
    chk("mul_al0", out[0], 32'd200);
    go(3'b000, 32'd10, 32'd20, 8'd1);
    chk("mul_al1", out[0], 32'd200);
    go(3'b000, 32'd10, 32'd20, 8'd2);
    chk("mul_al2_exact", out[0], 32'd200);
    go(3'b001, 32'h8000_0000, 32'h8000_0000, 8'd0);
    chk("mulh_min", out[0], 32'h4000_0000);
    go(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0);
    chk("mul_m1", out[0], 32'h0000_0001);
    go(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0);
    chk("mulhu_max", out[0], 32'hFFFF_FFFE);
    go(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0);
    chk("mulhsu", out[0], 32'hFFFF_FFFF);
    go(3'b001, 32'hFFFF_FFF9, 32'd3, 8'd0);
    chk("mulh_neg", out[0], 32'hFFFF_FFFF);
    go(3'b000, 32'hFFFF_FFF9, 32'd3, 8'd0);
    chk("mul_neg", out[0], 32'hFFFF_FFEB);
    opcode = 7'd0;
    edge1();
    set_op(3'b000, 32'd10, 32'd20, 8'd0);
    edge1();
    repeat (10) edge1();
    reset = 1'b0;
    #1;
    chk("rst_busy_now", {31'd0, busy[0]}, 32'd0);
    edge1();
    chk("rst_out", out[0], 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    edge1();
    reset = 1'b1;
    #1;
    wait_done();
    chk("rst_restart_latency", 32'(n), 32'd33);
    chk("rst_restart_out", out[0], 32'd200);
    go(3'b000, 32'd10, 32'd20, 8'd2);
    chk("approx_al2", out[1], 32'd160);
    chk("approx_al2_acc3", out[2], 32'd160);
    chk("exact_al2", out[0], 32'd200);
    go(3'b000, 32'd10, 32'd20, 8'd0);
    chk("approx_acc0", out[1], 32'd200);
    chk("approx_acc3", out[2], 32'd128);
    go(3'b000, 32'hFFFF_FFF9, 32'd3, 8'd0);
    funct3 = 3'b100;
    #1;
    chk("div_busy", {31'd0, busy[0]}, 32'd0);
    repeat (3) edge1();
    chk("div_out", out[0], 32'hFFFF_FFEB);
    funct3 = 3'b000;
    funct7 = 7'd0;
    #1;
    chk("add_busy", {31'd0, busy[0]}, 32'd0);
    repeat (3) edge1();
    chk("add_out", out[0], 32'hFFFF_FFEB);
    go(3'b000, 32'd10, 32'd20, 8'd0);
    chk("done_busy", {31'd0, busy[0]}, 32'd0);
    rs1 = 32'd11;
    #1;
    chk("change_busy", {31'd0, busy[0]}, 32'd1);
    wait_done();
    chk("change_latency", 32'(n), 32'd34);
    chk("change_out", out[0], 32'd220);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
